// File: rtl/program_sequencer.sv
// Program sequencer: fetches 16-bit instructions, runs flow control locally, issues core ops
// and packs output_bit samples into pixel words. SEQ_PERF_CNT_EN adds a busy-cycle counter.
module program_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int PIX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_data,
    output logic [15:0]           opcode,
    output logic                  execute,
    input  logic                  output_bit,
    output logic [PIX_WIDTH-1:0]  pixel,
    output logic                  pixel_valid,
`ifdef SEQ_PERF_CNT_EN
    output logic [15:0]           perf_cycles,
`endif
    input  logic                  pixel_ready
);
    localparam int CW = $clog2(PIX_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, CAPTURE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [15:0]            instr_q, instr_d;
    logic [15:0]            opcode_q, opcode_d;
    logic [PIX_WIDTH-1:0]   pixel_q, pixel_d;
    logic                   pix_vld_q, pix_vld_d;
    logic [CW-1:0]          bcnt_q, bcnt_d;
    logic                   out_op;

    assign out_op = (instr_q[15:14] == 2'b11) && instr_q[4];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        opcode_d  = opcode_q;
        pixel_d   = pixel_q;
        pix_vld_d = pix_vld_q;
        bcnt_d    = bcnt_q;
        execute   = 1'b0;
        if (pix_vld_q && pixel_ready)
            pix_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    instr_d = mem_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (instr_q[15:12])
                    4'b1011: begin
                        pc_d    = instr_q[ADDR_WIDTH-1:0];
                        state_d = FETCH;
                    end
                    4'b1001: begin
                        cnt_d   = instr_q[7:0];
                        pc_d    = pc_q + ADDR_WIDTH'(1);
                        state_d = FETCH;
                    end
                    4'b1000: begin
                        if (cnt_q != 8'd0) begin
                            cnt_d = cnt_q - 8'd1;
                            pc_d  = instr_q[ADDR_WIDTH-1:0];
                        end else begin
                            pc_d  = pc_q + ADDR_WIDTH'(1);
                        end
                        state_d = FETCH;
                    end
                    4'b1010: state_d = IDLE;
                    default: begin
                        // An output op may not start a new word while the last one is unaccepted.
                        if (!(out_op && pix_vld_q && !pixel_ready)) begin
                            execute  = 1'b1;
                            opcode_d = instr_q;
                            pc_d     = pc_q + ADDR_WIDTH'(1);
                            state_d  = out_op ? CAPTURE : FETCH;
                        end
                    end
                endcase
            end
            CAPTURE: begin
                pixel_d = PIX_WIDTH'({pixel_q, output_bit});
                if (bcnt_q == CW'(PIX_WIDTH - 1)) begin
                    bcnt_d    = '0;
                    pix_vld_d = 1'b1;
                end else begin
                    bcnt_d    = bcnt_q + CW'(1);
                end
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            instr_q   <= '0;
            opcode_q  <= '0;
            pixel_q   <= '0;
            pix_vld_q <= 1'b0;
            bcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            opcode_q  <= opcode_d;
            pixel_q   <= pixel_d;
            pix_vld_q <= pix_vld_d;
            bcnt_q    <= bcnt_d;
        end
    end

    // Opcode is presented in the issue cycle itself and held afterwards.
    assign opcode      = execute ? instr_q : opcode_q;
    assign busy        = (state_q != IDLE);
    assign mem_req     = (state_q == FETCH);
    assign mem_addr    = pc_q;
    assign pixel       = pixel_q;
    assign pixel_valid = pix_vld_q;

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE) begin
            if (start)
                perf_d = '0;
        end else if (perf_q != 16'hFFFF) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: memory responder, issue monitor and pixel consumer.
module tb_program_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = 16'h0;
    logic [15:0] opcode;
    logic        execute;
    logic        output_bit = 1'b0;
    logic [3:0]  pixel;
    logic        pixel_valid;
    logic        pixel_ready = 1'b0;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] perf_cycles;
`endif

    int total = 0;
    int bad = 0;

    logic [15:0] mem [256];
    int          lat = 0;
    int          wait_cnt = 0;
    int          exec_cnt = 0;
    logic [15:0] exec_log [$];
    logic [7:0]  fetch_log [$];
    logic [3:0]  pix_log [$];
    logic        bits [$];

    program_sequencer #(.ADDR_WIDTH(8), .PIX_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .opcode(opcode), .execute(execute), .output_bit(output_bit),
        .pixel(pixel), .pixel_valid(pixel_valid),
`ifdef SEQ_PERF_CNT_EN
        .perf_cycles(perf_cycles),
`endif
        .pixel_ready(pixel_ready)
    );

    always #5 clk = ~clk;

    // Program memory: acks after 'lat' waiting cycles, data valid with the ack.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wait_cnt >= lat) begin
                mem_ack  = 1'b1;
                mem_data = mem[mem_addr];
                fetch_log.push_back(mem_addr);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Core-array stand-in: output_bit appears after the issuing edge of an output op.
    always @(negedge clk) begin
        if (execute) begin
            exec_cnt++;
            exec_log.push_back(opcode);
            if (opcode[15:14] == 2'b11 && opcode[4])
                output_bit = (bits.size() > 0) ? bits.pop_front() : 1'b0;
        end
        if (pixel_valid && pixel_ready)
            pix_log.push_back(pixel);
    end

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000;
        exec_cnt = 0;
        exec_log.delete();
        fetch_log.delete();
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, want 0", busy, cyc);
        end
    endtask

    task automatic test_reset();
        int cyc;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        total++; if (mem_req !== 1'b0)     begin bad++; $display("FAIL rst_req: got %0b want 0", mem_req); end
        total++; if (execute !== 1'b0)     begin bad++; $display("FAIL rst_exec: got %0b want 0", execute); end
        total++; if (opcode !== 16'h0)     begin bad++; $display("FAIL rst_opcode: got %0h want 0", opcode); end
        total++; if (pixel !== 4'h0)       begin bad++; $display("FAIL rst_pixel: got %0h want 0", pixel); end
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL rst_pvalid: got %0b want 0", pixel_valid); end
        rst_n = 1'b1;
        clr_mem();
        lat = 5;
        kick();
        @(negedge clk);
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL midfetch_req: got %0b want 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL async_busy: got %0b want 0", busy); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL async_req: got %0b want 0", mem_req); end
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        clr_mem();
        kick();
        wait_idle(cyc);
        total++;
        if (fetch_log.size() != 1 || fetch_log[0] !== 8'h00) begin
            bad++; $display("FAIL rst_refetch: got %0d fetches first=%0h want 1 fetch at 0",
                            fetch_log.size(), (fetch_log.size() > 0) ? fetch_log[0] : 8'hxx);
        end
    endtask

    task automatic test_issue();
        int cyc;
        clr_mem();
        mem[0] = 16'h0123;
        kick();
        wait_idle(cyc);
        total++; if (exec_cnt != 1) begin bad++; $display("FAIL issue_cnt: got %0d want 1", exec_cnt); end
        total++; if (exec_log.size() == 0 || exec_log[0] !== 16'h0123) begin
            bad++; $display("FAIL issue_op: got %0d entries want opcode 0123", exec_log.size()); end
        total++; if (opcode !== 16'h0123) begin bad++; $display("FAIL issue_hold: got %0h want 0123", opcode); end
        total++; if (execute !== 1'b0)    begin bad++; $display("FAIL issue_exec_low: got %0b want 0", execute); end
        total++; if (cyc != 4)            begin bad++; $display("FAIL issue_busy_cycles: got %0d want 4", cyc); end
`ifdef SEQ_PERF_CNT_EN
        total++; if (perf_cycles !== 16'(cyc)) begin bad++; $display("FAIL perf: got %0d want %0d", perf_cycles, cyc); end
        repeat (3) @(negedge clk);
        total++; if (perf_cycles !== 16'(cyc)) begin bad++; $display("FAIL perf_frozen: got %0d want %0d", perf_cycles, cyc); end
`endif
    endtask

    task automatic test_loop();
        int cyc;
        int n_ok;
        clr_mem();
        mem[0] = 16'h9003;
        mem[1] = 16'h0042;
        mem[2] = 16'h8001;
        kick();
        wait_idle(cyc);
        n_ok = 0;
        foreach (exec_log[i]) if (exec_log[i] === 16'h0042) n_ok++;
        total++; if (exec_cnt != 4) begin bad++; $display("FAIL loop_cnt: got %0d want 4", exec_cnt); end
        total++; if (n_ok != 4)     begin bad++; $display("FAIL loop_ops: got %0d good ops want 4", n_ok); end
    endtask

    task automatic test_pixel();
        int cyc;
        clr_mem();
        pixel_ready = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 16'hC010;
        bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        kick();
        wait_idle(cyc);
        total++; if (exec_cnt != 4)        begin bad++; $display("FAIL pix_issue: got %0d want 4", exec_cnt); end
        total++; if (pixel_valid !== 1'b1) begin bad++; $display("FAIL pix_valid: got %0b want 1", pixel_valid); end
        total++; if (pixel !== 4'b1011)    begin bad++; $display("FAIL pix_word: got %b want 1011", pixel); end
    endtask

    task automatic test_backpressure();
        int cyc;
        clr_mem();
        pix_log.delete();
        mem[0] = 16'hC010;
        bits = '{1'b1};
        kick();
        repeat (20) @(negedge clk);
        total++; if (exec_cnt != 0)     begin bad++; $display("FAIL bp_stall: got %0d issues want 0", exec_cnt); end
        total++; if (busy !== 1'b1)     begin bad++; $display("FAIL bp_busy: got %0b want 1", busy); end
        total++; if (pixel !== 4'b1011) begin bad++; $display("FAIL bp_stable: got %b want 1011", pixel); end
        pixel_ready = 1'b1;
        wait_idle(cyc);
        total++; if (exec_cnt != 1) begin bad++; $display("FAIL bp_release: got %0d issues want 1", exec_cnt); end
        total++; if (pix_log.size() != 1 || pix_log[0] !== 4'b1011) begin
            bad++; $display("FAIL bp_handshake: got %0d words want one 1011", pix_log.size()); end
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL bp_partial: got %0b want 0", pixel_valid); end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [7:0] exp_addr [6];
        exp_addr = '{8'd0, 8'd1, 8'd2, 8'd255, 8'd0, 8'd3};
        clr_mem();
        mem[0]   = 16'h8003;
        mem[1]   = 16'h9001;
        mem[2]   = 16'hB0FF;
        mem[255] = 16'h0077;
        kick();
        wait_idle(cyc);
        total++; if (fetch_log.size() != 6) begin bad++; $display("FAIL wrap_len: got %0d want 6", fetch_log.size()); end
        for (int i = 0; i < 6 && i < fetch_log.size(); i++) begin
            total++;
            if (fetch_log[i] !== exp_addr[i]) begin
                bad++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, fetch_log[i], exp_addr[i]);
            end
        end
        total++; if (exec_cnt != 1 || opcode !== 16'h0077) begin
            bad++; $display("FAIL wrap_issue: got %0d issues op %0h want 1 op 0077", exec_cnt, opcode); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        clr_mem();
        lat = 2;
        mem[0] = 16'h0011;
        mem[1] = 16'h4022;
        mem[2] = 16'hC000;
        kick();
        cyc = 0;
        while (busy && cyc < 2000) begin
            start = (cyc == 5);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_done: got busy %0b want 0", busy); end
        total++; if (exec_log.size() != 3 || exec_log[0] !== 16'h0011 || exec_log[1] !== 16'h4022
                     || exec_log[2] !== 16'hC000) begin
            bad++; $display("FAIL b2b_ops: got %0d ops want 0011,4022,C000", exec_log.size()); end
        total++; if (fetch_log.size() != 4) begin bad++; $display("FAIL b2b_fetches: got %0d want 4", fetch_log.size()); end
        lat = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000;
        test_reset();
        test_issue();
        test_loop();
        test_pixel();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1);
    end
endmodule
